// File: rtl/combo_lock_driver.sv
// combo_lock_driver
//   Transmitter end of the two-button combination-lock interface. On an
//   accepted start it holds the target lock in reset for two cycles, plays
//   the latched code out as single-cycle button pulses separated by GAP_W
//   idle cycles, then waits up to TIMEOUT cycles for the lock's unlock flag.
//   A missing flag triggers a full retry, up to MAX_TRIES attempts in total.
//
// Ports
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-low reset
//   start       in   operation request, only looked at while idle
//   code        in   [LEN] press sequence, LSB first (0 = x, 1 = x1)
//   y           in   unlock flag from the lock (may be a 1-cycle pulse)
//   x, x1       out  button pulses to the lock
//   lock_rst_n  out  active-low reset to the lock
//   busy        out  high whenever an operation is in progress
//   done        out  1-cycle pulse at the end of an operation
//   success     out  result of the last operation
//   tries       out  [4] attempts used by the last/current operation
//
// Every output is a flop. Outputs are computed from the next-state values,
// so each output lines up exactly with the state it belongs to.

module combo_lock_driver #(
    parameter int LEN       = 5,
    parameter int GAP_W     = 2,
    parameter int TIMEOUT   = 8,
    parameter int MAX_TRIES = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic [LEN-1:0] code,
    input  logic           y,
    output logic           x,
    output logic           x1,
    output logic           lock_rst_n,
    output logic           busy,
    output logic           done,
    output logic           success,
    output logic [3:0]     tries
);

    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int CNT_W = 8;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LRST_LAST = CNT_W'(1);
    localparam logic [3:0]       MAX_T     = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LRST,
        S_PRESS,
        S_GAP,
        S_WAIT_ACK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;     // shared by LRST, GAP and WAIT_ACK
    logic [IDX_W-1:0] idx_q, idx_d;     // current press index
    logic [LEN-1:0]   code_q, code_d;
    logic [3:0]       tries_q, tries_d;
    logic             success_q, success_d;

    logic x_q, x_d;
    logic x1_q, x1_d;
    logic lrst_n_q, lrst_n_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        code_d    = code_q;
        tries_d   = tries_q;
        success_d = success_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    code_d    = code;
                    tries_d   = 4'd1;
                    success_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_LRST;
                end
            end

            S_LRST: begin
                if (cnt_q == LRST_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_PRESS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PRESS: begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    // Wait counter counts 1..TIMEOUT, so the first wait
                    // cycle already carries the value 1.
                    cnt_d   = CNT_W'(1);
                    state_d = S_WAIT_ACK;
                end else begin
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_PRESS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_ACK: begin
                // The flag wins over the timeout on the final wait cycle.
                if (y) begin
                    success_d = 1'b1;
                    state_d   = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d = '0;
                    if (tries_q < MAX_T) begin
                        tries_d = tries_q + 4'd1;
                        state_d = S_LRST;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // A start seen here is deliberately dropped; it is picked up
            // in IDLE on the following cycle if still asserted.
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, registered below
    // ------------------------------------------------------------------
    always_comb begin
        x_d      = 1'b0;
        x1_d     = 1'b0;
        lrst_n_d = 1'b1;
        busy_d   = (state_d != S_IDLE);
        done_d   = 1'b0;

        unique case (state_d)
            S_LRST:  lrst_n_d = 1'b0;
            S_PRESS: begin
                x_d  = ~code_d[idx_d];
                x1_d =  code_d[idx_d];
            end
            S_DONE,
            S_FAIL:  done_d = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            code_q    <= '0;
            tries_q   <= '0;
            success_q <= 1'b0;
            x_q       <= 1'b0;
            x1_q      <= 1'b0;
            lrst_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            code_q    <= code_d;
            tries_q   <= tries_d;
            success_q <= success_d;
            x_q       <= x_d;
            x1_q      <= x1_d;
            lrst_n_q  <= lrst_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x          = x_q;
    assign x1         = x1_q;
    assign lock_rst_n = lrst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign success    = success_q;
    assign tries      = tries_q;

endmodule
